// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and bubble-safe control.
// Define PIPE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
`else
  typedef enum logic {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_t;
`endif

  state_t            state_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  // ctrl_q is cleared whenever the stage empties, so an empty stage never drives control
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

`ifdef PIPE_SKID_EN
  logic              ready_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  // in_ready depends only on state, never on out_ready
  assign in_ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      ctrl_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= ONE;
            valid_q <= 1'b1;
            data_q  <= in_data;
            ctrl_q  <= in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            data_q <= in_data;
            ctrl_q <= in_ctrl;
          end else if (out_fire) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
          end else if (in_fire) begin
            state_q     <= TWO;
            ready_q     <= 1'b0;
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_q <= ONE;
            ready_q <= 1'b1;
            data_q  <= skid_data_q;
            ctrl_q  <= skid_ctrl_q;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          ctrl_q  <= '0;
        end
      endcase
    end
  end
`else
  // Single register: accept whenever the current entry leaves this cycle
  assign in_ready = (state_q == EMPTY) | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= ONE;
            valid_q <= 1'b1;
            data_q  <= in_data;
            ctrl_q  <= in_ctrl;
          end
        end
        ONE: begin
          if (in_fire) begin
            data_q <= in_data;
            ctrl_q <= in_ctrl;
          end else if (out_fire) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ctrl_q  <= '0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector tables, reset pulses, and random traffic vs a queue model.
module tb_pipe_stage_reg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic [7:0]  c;
    logic        orr;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_d;
    logic [7:0]  e_c;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } ent_t;

  vec_t        vecs[$];
  ent_t        mq[$];
  logic [15:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [15:0] d,
                              input logic [7:0] c, input logic orr, input logic e_ir,
                              input logic e_ov, input logic [15:0] e_d, input logic [7:0] e_c);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.c = c; v.orr = orr;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_c = e_c;
    return v;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic [15:0] d,
                       input logic [7:0] c, input logic orr);
    flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = orr;
  endtask

  // Called at a negedge: drive, check in_ready before the edge, check outputs after it
  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.fl, v.iv, v.d, v.c, v.orr);
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(v.e_ir));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({tag, "_out_data"}, 32'(out_data), 32'(v.e_d));
    check({tag, "_out_ctrl"}, 32'(out_ctrl), 32'(v.e_c));
  endtask

  // Reference: a FIFO of capacity 2 (skid) or 1 (plain), head shown on the outputs
  function automatic logic m_ready(input logic orr);
`ifdef PIPE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || orr;
`endif
  endfunction

  task automatic rand_cycle(input int n);
    logic fl, iv, orr, e_ir, in_f, out_f;
    logic [15:0] d;
    logic [7:0]  c;
    ent_t e;
    fl  = ($urandom_range(0, 15) == 0);
    iv  = ($urandom_range(0, 9) < 7);
    orr = ($urandom_range(0, 9) < 6);
    d   = 16'($urandom);
    c   = 8'($urandom);
    drive(fl, iv, d, c, orr);
    e_ir  = m_ready(orr);
    in_f  = iv && e_ir;
    out_f = (mq.size() > 0) && orr;
    #1;
    check($sformatf("rnd%0d_in_ready", n), 32'(in_ready), 32'(e_ir));
    @(posedge clk);
    if (out_f) void'(mq.pop_front());
    if (fl) mq.delete();
    else if (in_f) begin
      e.d = d; e.c = c;
      mq.push_back(e);
    end
    if (mq.size() > 0) m_last = mq[0].d;
    @(negedge clk);
    check($sformatf("rnd%0d_out_valid", n), 32'(out_valid), 32'(mq.size() > 0));
    check($sformatf("rnd%0d_out_data", n), 32'(out_data), 32'(m_last));
    check($sformatf("rnd%0d_out_ctrl", n), 32'(out_ctrl), (mq.size() > 0) ? 32'(mq[0].c) : 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 8'hFF, 1'b0);

    // Reset pulse mid-cycle with control inputs all ones
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b0, 1'b1, 16'(i), 8'(i), 1'b1, 1'b1, 1'b1, 16'(i), 8'(i)));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0008, 8'h00));
`ifdef PIPE_SKID_EN
    vecs.push_back(mk(0, 1, 16'h1111, 8'h11, 0, 1, 1, 16'h1111, 8'h11));
    vecs.push_back(mk(0, 1, 16'h2222, 8'h22, 0, 1, 1, 16'h1111, 8'h11));
    vecs.push_back(mk(0, 1, 16'h3333, 8'h33, 0, 0, 1, 16'h1111, 8'h11));
    vecs.push_back(mk(0, 1, 16'h3333, 8'h33, 1, 0, 1, 16'h2222, 8'h22));
    vecs.push_back(mk(0, 1, 16'h3333, 8'h33, 1, 1, 1, 16'h3333, 8'h33));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h3333, 8'h00));
    vecs.push_back(mk(0, 1, 16'hAAAA, 8'hAA, 0, 1, 1, 16'hAAAA, 8'hAA));
    vecs.push_back(mk(0, 1, 16'hBBBB, 8'hBB, 0, 1, 1, 16'hAAAA, 8'hAA));
    vecs.push_back(mk(1, 1, 16'hCCCC, 8'hCC, 0, 0, 0, 16'hAAAA, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'hAAAA, 8'h00));
    vecs.push_back(mk(0, 1, 16'hDDDD, 8'hDD, 0, 1, 1, 16'hDDDD, 8'hDD));
    vecs.push_back(mk(1, 1, 16'hCCCC, 8'hCC, 1, 1, 0, 16'hDDDD, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'hDDDD, 8'h00));
`else
    vecs.push_back(mk(0, 1, 16'h1234, 8'h01, 0, 1, 1, 16'h1234, 8'h01));
    vecs.push_back(mk(0, 1, 16'h5A5A, 8'h5A, 0, 0, 1, 16'h1234, 8'h01));
    vecs.push_back(mk(0, 1, 16'h5A5A, 8'h5A, 1, 1, 1, 16'h5A5A, 8'h5A));
    vecs.push_back(mk(0, 1, 16'hAAAA, 8'hAA, 0, 0, 1, 16'h5A5A, 8'h5A));
    vecs.push_back(mk(1, 1, 16'hCCCC, 8'hCC, 1, 1, 0, 16'h5A5A, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h5A5A, 8'h00));
    vecs.push_back(mk(1, 1, 16'hCCCC, 8'hCC, 0, 1, 0, 16'h5A5A, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h5A5A, 8'h00));
`endif
    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Reset while holding an entry; inputs offered during reset must not load
    apply_vec(mk(0, 1, 16'h7777, 8'h77, 0, 1, 1, 16'h7777, 8'h77), 99);
    drive(1'b0, 1'b0, 16'h0000, 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_ctrl", 32'(out_ctrl), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b1, 16'h9999, 8'hFF, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("inrst_out_valid", 32'(out_valid), 32'd0);
    check("inrst_out_data", 32'(out_data), 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    rst_n = 1'b1;
    mq.delete();
    m_last = 16'h0000;

    for (int n = 0; n < 500; n++) rand_cycle(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
